// File: rtl/serial_byte_deserializer_if.sv
// ----------------------------------------------------------------------------
// serial_byte_deserializer_if
// Byte output channel of the serial byte deserializer: a valid/ready handshake
// carrying one aligned byte at a time.
//   rx_data  : received byte, MSB = first bit on the wire (master -> slave)
//   rx_valid : rx_data holds an unconsumed byte              (master -> slave)
//   rx_ready : consumer accepts rx_data this cycle           (slave -> master)
// ----------------------------------------------------------------------------
interface serial_byte_deserializer_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  // The deserializer produces bytes
  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  // The downstream consumer accepts bytes
  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/serial_byte_deserializer.sv
// ----------------------------------------------------------------------------
// serial_byte_deserializer
// Samples an asynchronous serial line at mid-bit using the bit period supplied
// by the clock-recovery stage, hunts for SYNC_WORD, then delivers aligned
// bytes through a one-entry output buffer with a valid/ready handshake.
// Everything runs in the i_clk_200M domain.
//   i_clk_200M   : sole clock, rising edge
//   i_rst_n      : asynchronous active-low reset
//   i_signal     : raw serial input, asynchronous to i_clk_200M
//   i_bit_period : cycles per bit from the clock-recovery stage
//   i_clear_ovf  : one-cycle pulse clearing o_overflow
//   o_locked     : high while aligned to the byte stream
//   o_overflow   : sticky, a completed byte was dropped
//   rx_bus       : byte output channel (master side)
// ----------------------------------------------------------------------------
module serial_byte_deserializer #(
  parameter logic [7:0]  SYNC_WORD  = 8'hD5,
  parameter int unsigned MIN_PERIOD = 4,
  parameter int unsigned IDLE_BITS  = 64
) (
  input  logic        i_clk_200M,
  input  logic        i_rst_n,
  input  logic        i_signal,
  input  logic [15:0] i_bit_period,
  input  logic        i_clear_ovf,
  output logic        o_locked,
  output logic        o_overflow,
  serial_byte_deserializer_if.master rx_bus
);

  localparam logic [15:0] LP_MIN_PERIOD = 16'(MIN_PERIOD);
  localparam logic [7:0]  LP_IDLE_BITS  = 8'(IDLE_BITS);

  typedef enum logic [0:0] {HUNT, LOCKED} state_t;

  state_t      r_state;
  logic        r_s1, r_s2, r_s3;
  logic [15:0] r_per_q;
  logic [15:0] r_cnt;
  // Only the newest seven bits are needed to form the next byte, so the
  // oldest bit of the eight-bit window is never stored.
  logic [6:0]  r_sr;
  logic [7:0]  r_idle;
  logic [2:0]  r_bc;
  logic        r_locked;
  logic        r_overflow;
  logic        r_rx_valid;
  logic [7:0]  r_rx_data;

  logic        w_edge;
  logic        w_new_per_ok;
  logic        w_per_ok;
  logic        w_strobe;
  logic [7:0]  w_nxt;
  logic [7:0]  w_idle_inc;
  logic        w_timeout;
  logic        w_lose;
  logic        w_byte_done;
  logic        w_consume;

  assign w_edge       = r_s2 ^ r_s3;
  assign w_new_per_ok = (i_bit_period >= LP_MIN_PERIOD);
  assign w_per_ok     = (r_per_q >= LP_MIN_PERIOD);
  // An edge re-phases the counter, so it suppresses a coincident strobe.
  assign w_strobe     = !w_edge && w_per_ok && (r_cnt == 16'd0);
  assign w_nxt        = {r_sr, r_s2};
  assign w_idle_inc   = (r_idle == 8'hFF) ? r_idle : (r_idle + 8'd1);
  assign w_timeout    = w_strobe && (w_idle_inc == LP_IDLE_BITS);
  // An edge carrying an invalid period drops lock immediately rather than
  // waiting a cycle for the latched period to show it.
  assign w_lose       = !w_per_ok || (w_edge && !w_new_per_ok) || w_timeout;
  assign w_byte_done  = (r_state == LOCKED) && w_strobe && !w_timeout &&
                        (r_bc == 3'd7);
  assign w_consume    = r_rx_valid && rx_bus.rx_ready;

  // Synchronizer, period latch, mid-bit phase counter, shift register and
  // idle counter. The counter is loaded with half a period on each edge so
  // the strobe lands in the middle of the bit, then free-runs at one period.
  always_ff @(posedge i_clk_200M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_per_q <= 16'd0;
      r_cnt   <= 16'd0;
      r_sr    <= 7'd0;
      r_idle  <= 8'd0;
    end else begin
      r_s1 <= i_signal;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      if (w_edge) begin
        r_per_q <= i_bit_period;
        r_idle  <= 8'd0;
        if (w_new_per_ok) begin
          r_cnt <= (i_bit_period >> 1) - 16'd1;
        end else begin
          r_cnt <= 16'd0;
        end
      end else if (r_cnt == 16'd0) begin
        if (w_per_ok) begin
          r_cnt <= r_per_q - 16'd1;
        end
      end else begin
        r_cnt <= r_cnt - 16'd1;
      end
      if (w_strobe) begin
        r_sr   <= w_nxt[6:0];
        r_idle <= w_idle_inc;
      end
    end
  end

  // Alignment FSM. The sync byte only sets the bit counter to zero; the byte
  // boundary is then every eighth strobe until lock is lost.
  always_ff @(posedge i_clk_200M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= HUNT;
      r_locked <= 1'b0;
      r_bc     <= 3'd0;
    end else begin
      case (r_state)
        HUNT: begin
          if (w_strobe && (w_nxt == SYNC_WORD)) begin
            r_state  <= LOCKED;
            r_locked <= 1'b1;
            r_bc     <= 3'd0;
          end
        end
        LOCKED: begin
          if (w_lose) begin
            r_state  <= HUNT;
            r_locked <= 1'b0;
          end else if (w_strobe) begin
            r_bc <= r_bc + 3'd1;
          end
        end
        default: begin
          r_state  <= HUNT;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  // One-entry output buffer. A byte arriving while the buffer is being
  // emptied this cycle replaces it without a gap in rx_valid; a byte
  // arriving at a full, stalled buffer is dropped and flagged. A new
  // overflow takes priority over a simultaneous clear.
  always_ff @(posedge i_clk_200M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_data  <= 8'd0;
      r_rx_valid <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_byte_done && (!r_rx_valid || w_consume)) begin
        r_rx_data  <= w_nxt;
        r_rx_valid <= 1'b1;
      end else if (w_consume) begin
        r_rx_valid <= 1'b0;
      end
      if (w_byte_done && r_rx_valid && !w_consume) begin
        r_overflow <= 1'b1;
      end else if (i_clear_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign rx_bus.rx_data  = r_rx_data;
  assign rx_bus.rx_valid = r_rx_valid;
  assign o_locked        = r_locked;
  assign o_overflow      = r_overflow;

endmodule

// File: tb/tb_serial_byte_deserializer.sv
// ----------------------------------------------------------------------------
// tb_serial_byte_deserializer
// Directed bench for serial_byte_deserializer at 16 cycles per bit. Stimulus
// pushes each byte it expects delivered into a queue; a monitor on the
// falling edge pops and compares on every rx_valid & rx_ready transfer.
// ----------------------------------------------------------------------------
module tb_serial_byte_deserializer;

  logic        clk200M = 1'b0;
  logic        rstN;
  logic        serialIn;
  logic [15:0] bitPeriod;
  logic        clearOvf;
  logic        locked;
  logic        overflow;

  int          checkCount = 0;
  int          errorCount = 0;
  logic [7:0]  expectQ[$];
  logic [7:0]  expByte;
  logic [7:0]  lastByte;

  serial_byte_deserializer_if rxIf();

  serial_byte_deserializer dut (
    .i_clk_200M   (clk200M),
    .i_rst_n      (rstN),
    .i_signal     (serialIn),
    .i_bit_period (bitPeriod),
    .i_clear_ovf  (clearOvf),
    .o_locked     (locked),
    .o_overflow   (overflow),
    .rx_bus       (rxIf)
  );

  always #5 clk200M = ~clk200M;

  // Single comparison point: counts every check and reports any miss
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: every transfer must match the oldest expected byte
  always @(negedge clk200M) begin
    if (rstN && rxIf.rx_valid && rxIf.rx_ready) begin
      if (expectQ.size() == 0) begin
        checkCount++;
        errorCount++;
        $display("[TB] FAIL unexpected byte: got 0x%0h, expected none", rxIf.rx_data);
      end else begin
        expByte = expectQ.pop_front();
        checkOutput("rx_data transfer", {24'd0, rxIf.rx_data}, {24'd0, expByte});
      end
    end
  end

  // Hold one bit on the line for a full 16-cycle bit time
  task automatic sendBit(input logic b);
    serialIn = b;
    repeat (16) @(posedge clk200M);
    #1;
  endtask

  // Send one byte MSB first; optionally expect it at the output
  task automatic applyStimulus(input logic [7:0] b, input bit expectIt);
    if (expectIt) expectQ.push_back(b);
    for (int i = 7; i >= 0; i--) sendBit(b[i]);
  endtask

  task automatic doReset();
    checkOutput("queue drained", 32'(expectQ.size()), 32'd0);
    expectQ.delete();
    rstN = 1'b0;
    repeat (3) @(posedge clk200M);
    #1;
    rstN = 1'b1;
    serialIn = 1'b0;
    repeat (4) @(posedge clk200M);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN          = 1'b0;
    serialIn      = 1'b0;
    bitPeriod     = 16'd16;
    clearOvf      = 1'b0;
    rxIf.rx_ready = 1'b0;
    repeat (2) @(posedge clk200M);
    #1;
    checkOutput("reset rx_valid", {31'd0, rxIf.rx_valid}, 32'd0);
    checkOutput("reset rx_data", {24'd0, rxIf.rx_data}, 32'd0);
    checkOutput("reset locked", {31'd0, locked}, 32'd0);
    checkOutput("reset overflow", {31'd0, overflow}, 32'd0);
    rstN = 1'b1;
    repeat (4) @(posedge clk200M);
    #1;

    // Basic receive with the consumer always ready
    $display("[TB] basic receive");
    rxIf.rx_ready = 1'b1;
    applyStimulus(8'hAA, 1'b0);
    checkOutput("hunt before sync", {31'd0, locked}, 32'd0);
    applyStimulus(8'hD5, 1'b0);
    checkOutput("locked after sync", {31'd0, locked}, 32'd1);
    applyStimulus(8'h3C, 1'b1);
    applyStimulus(8'hA5, 1'b1);
    checkOutput("still locked", {31'd0, locked}, 32'd1);
    checkOutput("valid pulse ended", {31'd0, rxIf.rx_valid}, 32'd0);
    doReset();

    // Asynchronous reset in the middle of a byte
    $display("[TB] reset mid-byte");
    rxIf.rx_ready = 1'b0;
    applyStimulus(8'hAA, 1'b0);
    applyStimulus(8'hD5, 1'b0);
    applyStimulus(8'h3C, 1'b0);
    checkOutput("held byte valid", {31'd0, rxIf.rx_valid}, 32'd1);
    checkOutput("held byte data", {24'd0, rxIf.rx_data}, 32'h3C);
    sendBit(1'b0);
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b1);
    serialIn = 1'b1;
    repeat (5) @(posedge clk200M);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("async reset rx_valid", {31'd0, rxIf.rx_valid}, 32'd0);
    checkOutput("async reset rx_data", {24'd0, rxIf.rx_data}, 32'd0);
    checkOutput("async reset locked", {31'd0, locked}, 32'd0);
    checkOutput("async reset overflow", {31'd0, overflow}, 32'd0);
    repeat (3) @(posedge clk200M);
    #1;
    rstN = 1'b1;
    repeat (8) @(posedge clk200M);
    #1;
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b0);
    rxIf.rx_ready = 1'b1;
    applyStimulus(8'h33, 1'b0);
    checkOutput("no relock 1", {31'd0, locked}, 32'd0);
    applyStimulus(8'h33, 1'b0);
    checkOutput("no relock 2", {31'd0, locked}, 32'd0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'hAA, 1'b0);
    checkOutput("no relock 3", {31'd0, locked}, 32'd0);
    applyStimulus(8'hD5, 1'b0);
    checkOutput("relock on sync", {31'd0, locked}, 32'd1);
    doReset();

    // Backpressure: second byte overflows, third is dropped too
    $display("[TB] backpressure");
    rxIf.rx_ready = 1'b0;
    applyStimulus(8'hAA, 1'b0);
    applyStimulus(8'hD5, 1'b0);
    applyStimulus(8'h11, 1'b1);
    checkOutput("bp first valid", {31'd0, rxIf.rx_valid}, 32'd1);
    checkOutput("bp first overflow", {31'd0, overflow}, 32'd0);
    applyStimulus(8'h22, 1'b0);
    checkOutput("bp data held", {24'd0, rxIf.rx_data}, 32'h11);
    checkOutput("bp overflow set", {31'd0, overflow}, 32'd1);
    applyStimulus(8'h33, 1'b0);
    checkOutput("bp data still held", {24'd0, rxIf.rx_data}, 32'h11);
    rxIf.rx_ready = 1'b1;
    @(posedge clk200M);
    #1;
    rxIf.rx_ready = 1'b0;
    checkOutput("bp consumed", {31'd0, rxIf.rx_valid}, 32'd0);
    checkOutput("bp overflow sticky", {31'd0, overflow}, 32'd1);
    clearOvf = 1'b1;
    @(posedge clk200M);
    #1;
    clearOvf = 1'b0;
    checkOutput("bp overflow cleared", {31'd0, overflow}, 32'd0);
    doReset();

    // Consume on exactly the cycle the next byte completes. The last bit's
    // edge reaches the counter 3 cycles after the drive and the strobe comes
    // 8 cycles after that, so the completion edge is the 11th after the drive.
    $display("[TB] simultaneous consume");
    rxIf.rx_ready = 1'b0;
    applyStimulus(8'hAA, 1'b0);
    applyStimulus(8'hD5, 1'b0);
    applyStimulus(8'h44, 1'b1);
    lastByte = 8'h66;
    expectQ.push_back(lastByte);
    for (int i = 7; i >= 1; i--) sendBit(lastByte[i]);
    serialIn = lastByte[0];
    repeat (10) @(posedge clk200M);
    #1;
    rxIf.rx_ready = 1'b1;
    checkOutput("sim old byte valid", {31'd0, rxIf.rx_valid}, 32'd1);
    @(posedge clk200M);
    #1;
    rxIf.rx_ready = 1'b0;
    checkOutput("sim no gap", {31'd0, rxIf.rx_valid}, 32'd1);
    checkOutput("sim new data", {24'd0, rxIf.rx_data}, 32'h66);
    checkOutput("sim no overflow", {31'd0, overflow}, 32'd0);
    repeat (3) @(posedge clk200M);
    #1;
    rxIf.rx_ready = 1'b1;
    @(posedge clk200M);
    #1;
    checkOutput("sim drained", {31'd0, rxIf.rx_valid}, 32'd0);
    doReset();

    // Period below the minimum never samples, then a valid period locks
    $display("[TB] invalid period");
    rxIf.rx_ready = 1'b1;
    bitPeriod = 16'd3;
    applyStimulus(8'hAA, 1'b0);
    applyStimulus(8'hD5, 1'b0);
    applyStimulus(8'hAA, 1'b0);
    checkOutput("bad period not locked", {31'd0, locked}, 32'd0);
    checkOutput("bad period no data", {31'd0, rxIf.rx_valid}, 32'd0);
    bitPeriod = 16'd16;
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'hAA, 1'b0);
    applyStimulus(8'hD5, 1'b0);
    checkOutput("good period locked", {31'd0, locked}, 32'd1);
    applyStimulus(8'h77, 1'b1);
    doReset();

    // Idle timeout: line held high after sync. The sync strobe is the first
    // edgeless one; the 63rd strobe after it times out at cycle 11 + 63*16
    // after the sync's last bit was driven. Seven 0xFF bytes finish first.
    $display("[TB] idle timeout");
    rxIf.rx_ready = 1'b1;
    applyStimulus(8'hAA, 1'b0);
    for (int i = 0; i < 7; i++) expectQ.push_back(8'hFF);
    applyStimulus(8'hD5, 1'b0);
    repeat (1002) @(posedge clk200M);
    #1;
    checkOutput("idle still locked", {31'd0, locked}, 32'd1);
    @(posedge clk200M);
    #1;
    checkOutput("idle lock lost", {31'd0, locked}, 32'd0);
    repeat (300) @(posedge clk200M);
    #1;
    checkOutput("idle stays unlocked", {31'd0, locked}, 32'd0);
    doReset();

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
